alu_issue_sequencer: RTL and testbench
======================================

# alu_issue_sequencer

Sequencing controller between the ALU instruction decoder and the shared ALU/register-file write port. It accepts one decoded ALU instruction at a time over a valid/ready handshake and launches it on the multi-cycle ALU. It waits a fixed latency, captures both results, and serializes up to two destination writes (Y1, then Y2) onto the register file's single write port. Invalid instructions are dropped with a one-cycle trap pulse.

## Interface
Parameters:
- LATENCY, 2, ALU cycles from issue to result valid; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  sequencer can accept; high only in IDLE
- invalid_instruction  in  1  decoder invalid flag, qualified by dec_valid
- alu_a_select, alu_b_select, alu_c_select, alu_d_select  in  4 each  source register selects
- alu_Y1_select, alu_Y2_select  in  4 each  destination register selects
- alu_write  in  2  destination write mask; [0]=Y1, [1]=Y2
- iss_a_sel, iss_b_sel, iss_c_sel, iss_d_sel  out  4 each  latched source selects to register-file read ports; held stable from issue until IDLE
- issue  out  1  one-cycle ALU launch pulse
- res_y1, res_y2  in  32 each  ALU results; valid in the final EXEC cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  write address
- rf_wdata  out  32  write data
- done  out  1  high in the final cycle of each accepted, valid instruction
- trap  out  1  one-cycle pulse when an invalid instruction is consumed

## Operation
- States: IDLE, EXEC, WB1, WB2. Counter cnt is 4 bits.
- IDLE: dec_ready=1.
  - dec_valid & invalid_instruction: instruction is consumed and discarded. trap=1 in the next cycle. State stays IDLE; no other register changes.
  - dec_valid & ~invalid_instruction: latch the four source selects, Y1/Y2 selects and alu_write. Load cnt=LATENCY-1. Go to EXEC.
- EXEC: issue=1 in the first EXEC cycle only. cnt decrements each cycle.
  - When cnt==0: capture res_y1/res_y2.
  - Next state is WB1 if mask[0], else WB2 if mask[1], else IDLE. With mask 00, done=1 in this cycle.
- WB1: rf_we=1, rf_waddr=Y1, rf_wdata=captured y1. Next state is WB2 if mask[1], else IDLE. done=1 when going to IDLE.
- WB2: rf_we=1, rf_waddr=Y2, rf_wdata=captured y2, done=1. Next state is IDLE.
- rf_we is never asserted for address 0. A latched mask bit with a zero select is cleared at accept and that writeback state is skipped.
- Y1==Y2 with both mask bits set: both writes occur in order, so Y2's data wins.
- rf_waddr/rf_wdata are 0 whenever rf_we=0.
- No combinational path from dec_valid to dec_ready.

## Timing
- Handshake completes on the edge ending cycle T, where dec_valid & dec_ready.
- Issue, for any LATENCY: issue high in cycle T+1.
- Result capture: results are sampled on the edge ending cycle T+LATENCY.
- Writebacks: WB1 occurs in cycle T+LATENCY+1, WB2 in T+LATENCY+1 or T+LATENCY+2 depending on mask.
- Next accept, by mask:
  - mask 11: next accept no earlier than cycle T+LATENCY+3.
  - mask 01 or 10: next accept no earlier than T+LATENCY+2.
  - mask 00: next accept no earlier than T+LATENCY+1.
- Invalid instruction: trap high in cycle T+1. dec_ready stays high, so back-to-back invalid instructions are accepted every cycle.
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, all latched selects/mask/data = 0.
  - issue, rf_we, rf_waddr, rf_wdata, done, trap and iss_*_sel are all 0.
  - dec_ready=1 once state is IDLE.
  - Reset mid-operation abandons the instruction; no partial write occurs after deassertion.
- Inputs are sampled only at accept (decoder fields) or at cnt==0 in EXEC (results). Changes at any other time have no effect.

## Test plan
- Reset, then LATENCY=2, accept Y1=3, Y2=5, mask=11, with res_y1=0xAAAA0001 and res_y2=0x5555_0002 at T+2 -> issue at T+1; rf_we at T+3 (addr 3, 0xAAAA0001) and T+4 (addr 5, 0x55550002); done at T+4; dec_ready high at T+5.
- dec_valid with invalid_instruction=1 for 3 consecutive cycles -> trap pulses in 3 consecutive cycles; no issue, no rf_we; dec_ready constant 1.
- mask=11 with Y1=0, Y2=7 -> single write to addr 7 at T+LATENCY+1; done in that cycle.
- mask=00 with LATENCY=1 -> issue and done both in T+1; no rf_we; accept possible again at T+2.
- Y1=Y2=9, mask=11, y1=1, y2=2 -> writes 1 then 2 to addr 9 in consecutive cycles.
- rst_n pulsed low during WB1 -> outputs 0 immediately; after release, no rf_we occurs, dec_ready=1, and the next instruction runs normally.

Source files
------------

// File: rtl/alu_issue_sequencer_if.sv
// rtl/alu_issue_sequencer_if.sv - decoder, ALU and register-file write bundle for the issue sequencer
interface alu_issue_sequencer_if;
  logic        dec_valid;
  logic        dec_ready;
  logic        invalid_instruction;
  logic [3:0]  alu_a_select;
  logic [3:0]  alu_b_select;
  logic [3:0]  alu_c_select;
  logic [3:0]  alu_d_select;
  logic [3:0]  alu_Y1_select;
  logic [3:0]  alu_Y2_select;
  logic [1:0]  alu_write;
  logic [3:0]  iss_a_sel;
  logic [3:0]  iss_b_sel;
  logic [3:0]  iss_c_sel;
  logic [3:0]  iss_d_sel;
  logic        issue;
  logic [31:0] res_y1;
  logic [31:0] res_y2;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done;
  logic        trap;

  modport master (
    output dec_valid, invalid_instruction,
    output alu_a_select, alu_b_select, alu_c_select, alu_d_select,
    output alu_Y1_select, alu_Y2_select, alu_write, res_y1, res_y2,
    input  dec_ready, iss_a_sel, iss_b_sel, iss_c_sel, iss_d_sel,
    input  issue, rf_we, rf_waddr, rf_wdata, done, trap
  );

  modport slave (
    input  dec_valid, invalid_instruction,
    input  alu_a_select, alu_b_select, alu_c_select, alu_d_select,
    input  alu_Y1_select, alu_Y2_select, alu_write, res_y1, res_y2,
    output dec_ready, iss_a_sel, iss_b_sel, iss_c_sel, iss_d_sel,
    output issue, rf_we, rf_waddr, rf_wdata, done, trap
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - issues one ALU op, waits LATENCY cycles, serializes Y1/Y2 writebacks
module alu_issue_sequencer #(
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_issue_sequencer_if.slave  seq
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB1, S_WB2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic        trap_q, trap_d;
  logic [15:0] src_q, src_d;
  logic [3:0]  y1sel_q, y1sel_d;
  logic [3:0]  y2sel_q, y2sel_d;
  logic [1:0]  mask_q, mask_d;
  logic [31:0] y1_q, y1_d;
  logic [31:0] y2_q, y2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      trap_q  <= 1'b0;
      src_q   <= '0;
      y1sel_q <= '0;
      y2sel_q <= '0;
      mask_q  <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      trap_q  <= trap_d;
      src_q   <= src_d;
      y1sel_q <= y1sel_d;
      y2sel_q <= y2sel_d;
      mask_q  <= mask_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    trap_d  = 1'b0;
    src_d   = src_q;
    y1sel_d = y1sel_q;
    y2sel_d = y2sel_q;
    mask_d  = mask_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    unique case (state_q)
      S_IDLE: begin
        if (seq.dec_valid) begin
          if (seq.invalid_instruction) begin
            trap_d = 1'b1;
          end else begin
            src_d   = {seq.alu_a_select, seq.alu_b_select, seq.alu_c_select, seq.alu_d_select};
            y1sel_d = seq.alu_Y1_select;
            y2sel_d = seq.alu_Y2_select;
            // Writes to register 0 are dropped at accept so WB never targets it.
            mask_d  = {seq.alu_write[1] & (|seq.alu_Y2_select),
                       seq.alu_write[0] & (|seq.alu_Y1_select)};
            cnt_d   = CNT_INIT;
            first_d = 1'b1;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          y1_d = seq.res_y1;
          y2_d = seq.res_y2;
          if (mask_q[0])      state_d = S_WB1;
          else if (mask_q[1]) state_d = S_WB2;
          else                state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB1:   state_d = mask_q[1] ? S_WB2 : S_IDLE;
      S_WB2:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    seq.dec_ready = (state_q == S_IDLE);
    seq.issue     = first_q;
    seq.trap      = trap_q;
    seq.rf_we     = 1'b0;
    seq.rf_waddr  = '0;
    seq.rf_wdata  = '0;
    seq.done      = 1'b0;
    unique case (state_q)
      S_EXEC:  seq.done = (cnt_q == 4'd0) && (mask_q == 2'b00);
      S_WB1: begin
        seq.rf_we    = 1'b1;
        seq.rf_waddr = y1sel_q;
        seq.rf_wdata = y1_q;
        seq.done     = ~mask_q[1];
      end
      S_WB2: begin
        seq.rf_we    = 1'b1;
        seq.rf_waddr = y2sel_q;
        seq.rf_wdata = y2_q;
        seq.done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign seq.iss_a_sel = src_q[15:12];
  assign seq.iss_b_sel = src_q[11:8];
  assign seq.iss_c_sel = src_q[7:4];
  assign seq.iss_d_sel = src_q[3:0];

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb/tb_alu_issue_sequencer.sv - random and directed check of two sequencers (LATENCY 2 and 1)
module tb_alu_issue_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        dec_valid, inv;
  logic [3:0]  sa, sb, sc, sd, sy1, sy2;
  logic [1:0]  wm;
  logic [31:0] r1, r2;

  logic        ob_ready[2], ob_issue[2], ob_we[2], ob_done[2], ob_trap[2];
  logic [3:0]  ob_waddr[2];
  logic [31:0] ob_wdata[2];
  logic [15:0] ob_sel[2];

  alu_issue_sequencer_if ifs[2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign ifs[g].dec_valid           = dec_valid;
    assign ifs[g].invalid_instruction = inv;
    assign ifs[g].alu_a_select        = sa;
    assign ifs[g].alu_b_select        = sb;
    assign ifs[g].alu_c_select        = sc;
    assign ifs[g].alu_d_select        = sd;
    assign ifs[g].alu_Y1_select       = sy1;
    assign ifs[g].alu_Y2_select       = sy2;
    assign ifs[g].alu_write           = wm;
    assign ifs[g].res_y1              = r1;
    assign ifs[g].res_y2              = r2;
    assign ob_ready[g] = ifs[g].dec_ready;
    assign ob_issue[g] = ifs[g].issue;
    assign ob_we[g]    = ifs[g].rf_we;
    assign ob_waddr[g] = ifs[g].rf_waddr;
    assign ob_wdata[g] = ifs[g].rf_wdata;
    assign ob_done[g]  = ifs[g].done;
    assign ob_trap[g]  = ifs[g].trap;
    assign ob_sel[g]   = {ifs[g].iss_a_sel, ifs[g].iss_b_sel, ifs[g].iss_c_sel, ifs[g].iss_d_sel};

    alu_issue_sequencer #(.LATENCY(g == 0 ? 2 : 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seq   (ifs[g])
    );
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Transaction-level reference: an accepted op at cycle T owns the unit until T+L+writes.
  int          lat[2] = '{2, 1};
  bit          job[2];
  int          t0[2];
  logic [3:0]  m_y1s[2], m_y2s[2];
  bit          m_w1[2], m_w2[2];
  logic [31:0] m_y1[2], m_y2[2];
  logic [15:0] m_sel[2];
  bit          m_trap[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      job[k] = 0; m_sel[k] = '0; m_trap[k] = 0;
    end
  endtask

  task automatic check_idle_zero(input int k, input string ph);
    check_eq($sformatf("%s%0d_ready", ph, k), ob_ready[k], 1);
    check_eq($sformatf("%s%0d_issue", ph, k), ob_issue[k], 0);
    check_eq($sformatf("%s%0d_we", ph, k), ob_we[k], 0);
    check_eq($sformatf("%s%0d_waddr", ph, k), ob_waddr[k], 0);
    check_eq($sformatf("%s%0d_wdata", ph, k), ob_wdata[k], 0);
    check_eq($sformatf("%s%0d_done", ph, k), ob_done[k], 0);
    check_eq($sformatf("%s%0d_trap", ph, k), ob_trap[k], 0);
    check_eq($sformatf("%s%0d_sel", ph, k), ob_sel[k], 0);
  endtask

  task automatic eval_cycle();
    for (int k = 0; k < 2; k++) begin
      int nw, last, idx;
      bit busy, e_we;
      logic [3:0]  e_addr;
      logic [31:0] e_data;
      if (!rst_n) begin
        clear_model();
        check_idle_zero(k, "rst");
        continue;
      end
      nw   = int'(m_w1[k]) + int'(m_w2[k]);
      last = t0[k] + lat[k] + nw;
      busy = job[k] && cyc <= last;
      idx  = cyc - (t0[k] + lat[k] + 1);
      e_we = busy && idx >= 0;
      e_addr = '0; e_data = '0;
      if (e_we) begin
        if (idx == 0 && m_w1[k]) begin e_addr = m_y1s[k]; e_data = m_y1[k]; end
        else                     begin e_addr = m_y2s[k]; e_data = m_y2[k]; end
      end
      check_eq($sformatf("d%0d_ready", k), ob_ready[k], !busy);
      check_eq($sformatf("d%0d_issue", k), ob_issue[k], busy && cyc == t0[k] + 1);
      check_eq($sformatf("d%0d_we", k), ob_we[k], e_we);
      check_eq($sformatf("d%0d_waddr", k), ob_waddr[k], e_addr);
      check_eq($sformatf("d%0d_wdata", k), ob_wdata[k], e_data);
      check_eq($sformatf("d%0d_done", k), ob_done[k], busy && cyc == last);
      check_eq($sformatf("d%0d_trap", k), ob_trap[k], m_trap[k]);
      check_eq($sformatf("d%0d_sel", k), ob_sel[k], m_sel[k]);
      if (busy && cyc == t0[k] + lat[k]) begin m_y1[k] = r1; m_y2[k] = r2; end
      if (busy && cyc == last) job[k] = 0;
      m_trap[k] = 0;
      if (!busy && dec_valid) begin
        if (inv) m_trap[k] = 1;
        else begin
          job[k] = 1; t0[k] = cyc;
          m_sel[k] = {sa, sb, sc, sd};
          m_y1s[k] = sy1; m_y2s[k] = sy2;
          m_w1[k] = wm[0] && sy1 != 0;
          m_w2[k] = wm[1] && sy2 != 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((job[0] || job[1]) && n < 50) begin tick(); n++; end
    check_eq("idle_bound", n < 50, 1);
  endtask

  task automatic send(input logic [3:0] y1s, input logic [3:0] y2s, input logic [1:0] w,
                      input logic [31:0] a1, input logic [31:0] a2);
    wait_idle();
    sa = 4'd1; sb = 4'd2; sc = 4'd3; sd = 4'd4;
    sy1 = y1s; sy2 = y2s; wm = w; r1 = a1; r2 = a2;
    dec_valid = 1; inv = 0;
    tick();
    dec_valid = 0;
    repeat (6) tick();
  endtask

  task automatic rand_fields();
    sa = 4'($urandom); sb = 4'($urandom); sc = 4'($urandom); sd = 4'($urandom);
    sy1 = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
    case ($urandom_range(0, 5))
      0, 1:    sy2 = sy1;
      2:       sy2 = 4'd0;
      default: sy2 = 4'($urandom);
    endcase
    wm = 2'($urandom);
    r1 = $urandom; r2 = $urandom;
  endtask

  initial begin
    rst_n = 0; dec_valid = 0; inv = 0;
    sa = '0; sb = '0; sc = '0; sd = '0; sy1 = '0; sy2 = '0; wm = '0; r1 = '0; r2 = '0;
    clear_model();
    repeat (3) tick();
    rst_n = 1;

    send(4'd3, 4'd5, 2'b11, 32'hAAAA0001, 32'h55550002);

    dec_valid = 1; inv = 1;
    repeat (3) tick();
    dec_valid = 0; inv = 0;
    tick();

    send(4'd0, 4'd7, 2'b11, 32'h12345678, 32'h0BADF00D);

    wait_idle();
    sy1 = 4'd2; sy2 = 4'd6; wm = 2'b00; dec_valid = 1;
    tick();
    sy1 = 4'd8; wm = 2'b01; r1 = 32'hCAFE0001;
    tick();
    dec_valid = 0;
    repeat (5) tick();

    send(4'd9, 4'd9, 2'b11, 32'd1, 32'd2);

    wait_idle();
    sy1 = 4'd4; sy2 = 4'd6; wm = 2'b11; r1 = 32'hDEAD0004; r2 = 32'hBEEF0006; dec_valid = 1;
    tick();
    dec_valid = 0;
    repeat (2) tick();
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) check_idle_zero(k, "async");
    tick();
    rst_n = 1;
    repeat (4) tick();
    send(4'd11, 4'd12, 2'b11, 32'h0000_0B0B, 32'h0000_0C0C);

    repeat (600) begin
      rand_fields();
      dec_valid = ($urandom_range(0, 9) < 7);
      inv = ($urandom_range(0, 4) == 0);
      tick();
    end
    dec_valid = 0;
    wait_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
